// File: rtl/sha256_block_core_if.sv
// Block/digest handshake bundle for sha256_block_core: block offer on one side,
// chained digest on the other.
interface sha256_block_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_block;
  logic         in_chain;
  logic [255:0] h_in;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] digest;
  logic         busy;

  modport master (
    output in_valid, in_block, in_chain, h_in, out_ready,
    input  in_ready, out_valid, digest, busy
  );

  modport slave (
    input  in_valid, in_block, in_chain, h_in, out_ready,
    output in_ready, out_valid, digest, busy
  );
endinterface

// File: rtl/sha256_block_core.sv
// SHA-256 compression engine, ROUNDS_PER_CYCLE rounds per clock, internal chaining.
// Optional macro SHA256_BSWAP_EN byte-reverses each in_block word at acceptance.
module sha256_block_core #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  sha256_block_core_if.slave bus
);
  localparam int unsigned R = ROUNDS_PER_CYCLE;

  generate
    if (R != 1 && R != 2 && R != 4) begin : g_bad_rounds
      $error("sha256_block_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FINAL, S_OUT} state_t;

  state_t       state, state_next;
  logic [6:0]   t;
  logic [31:0]  w   [16];
  logic [31:0]  v   [8];
  logic [31:0]  hb  [8];
  logic [31:0]  ext [16+R];
  logic [31:0]  rv  [8];
  logic [31:0]  t1, t2;
  logic [5:0]   kidx;
  logic [255:0] digest_q;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] in_word(input logic [31:0] x);
`ifdef SHA256_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (bus.in_valid) state_next = S_COMPUTE;
      S_COMPUTE: if (t == 7'(64 - R)) state_next = S_FINAL;
      S_FINAL:   state_next = S_OUT;
      S_OUT:     if (bus.out_ready) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // ext[0..15] is W[t..t+15]; ext[16..] extends the schedule so all R rounds see their word at ext[j].
  always_comb begin
    ext  = '{default: '0};
    rv   = v;
    t1   = '0;
    t2   = '0;
    kidx = '0;
    for (int unsigned i = 0; i < 16; i++) ext[i] = w[i];
    for (int unsigned i = 16; i < 16 + R; i++)
      ext[i] = ssig1(ext[i-2]) + ext[i-7] + ssig0(ext[i-15]) + ext[i-16];
    for (int unsigned j = 0; j < R; j++) begin
      kidx  = t[5:0] + 6'(j);
      t1    = rv[7] + bsig1(rv[4]) + ((rv[4] & rv[5]) ^ (~rv[4] & rv[6])) + K[kidx] + ext[j];
      t2    = bsig0(rv[0]) + ((rv[0] & rv[1]) ^ (rv[0] & rv[2]) ^ (rv[1] & rv[2]));
      rv[7] = rv[6];
      rv[6] = rv[5];
      rv[5] = rv[4];
      rv[4] = rv[3] + t1;
      rv[3] = rv[2];
      rv[2] = rv[1];
      rv[1] = rv[0];
      rv[0] = t1 + t2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t        <= '0;
      w        <= '{default: '0};
      v        <= '{default: '0};
      hb       <= '{default: '0};
      digest_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (bus.in_valid) begin
          t <= '0;
          for (int unsigned i = 0; i < 16; i++) w[i] <= in_word(bus.in_block[511 - 32*i -: 32]);
          for (int unsigned i = 0; i < 8; i++) begin
            v[i]  <= bus.in_chain ? digest_q[255 - 32*i -: 32] : bus.h_in[255 - 32*i -: 32];
            hb[i] <= bus.in_chain ? digest_q[255 - 32*i -: 32] : bus.h_in[255 - 32*i -: 32];
          end
        end
        S_COMPUTE: begin
          t <= t + 7'(R);
          v <= rv;
          for (int unsigned i = 0; i < 16; i++) w[i] <= ext[i + R];
        end
        // digest_q doubles as the chaining register for the next in_chain=1 block.
        S_FINAL: for (int unsigned i = 0; i < 8; i++) digest_q[255 - 32*i -: 32] <= v[i] + hb[i];
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_OUT);
  assign bus.busy      = (state != S_IDLE);
  assign bus.digest    = digest_q;
endmodule

// File: tb/tb_sha256_block_core.sv
// Self-checking bench: three cores (R=1,2,4) driven in lockstep, checked against
// known FIPS digests and a whole-block reference model.
module tb_sha256_block_core;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid, in_chain, out_ready;
  logic [511:0] in_block;
  logic [255:0] h_in;

  int total = 0;
  int bad   = 0;
  logic [255:0] model_chain;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIG = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [511:0] TWO_B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] TWO_DIG = {32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                                      32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
  localparam int LAT [3] = '{65, 33, 17};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_block_core_if if_r1 ();
  sha256_block_core_if if_r2 ();
  sha256_block_core_if if_r4 ();

  sha256_block_core #(.ROUNDS_PER_CYCLE(1)) u_r1 (.clk(clk), .reset_n(reset_n), .bus(if_r1));
  sha256_block_core #(.ROUNDS_PER_CYCLE(2)) u_r2 (.clk(clk), .reset_n(reset_n), .bus(if_r2));
  sha256_block_core #(.ROUNDS_PER_CYCLE(4)) u_r4 (.clk(clk), .reset_n(reset_n), .bus(if_r4));

  assign if_r1.in_valid = in_valid;  assign if_r1.in_block = in_block;  assign if_r1.in_chain = in_chain;
  assign if_r1.h_in     = h_in;      assign if_r1.out_ready = out_ready;
  assign if_r2.in_valid = in_valid;  assign if_r2.in_block = in_block;  assign if_r2.in_chain = in_chain;
  assign if_r2.h_in     = h_in;      assign if_r2.out_ready = out_ready;
  assign if_r4.in_valid = in_valid;  assign if_r4.in_block = in_block;  assign if_r4.in_chain = in_chain;
  assign if_r4.h_in     = h_in;      assign if_r4.out_ready = out_ready;

  logic [255:0] dg [3];
  logic         ov [3], ir [3], bz [3];
  assign dg[0] = if_r1.digest;  assign ov[0] = if_r1.out_valid;  assign ir[0] = if_r1.in_ready;  assign bz[0] = if_r1.busy;
  assign dg[1] = if_r2.digest;  assign ov[1] = if_r2.out_valid;  assign ir[1] = if_r2.in_ready;  assign bz[1] = if_r2.busy;
  assign dg[2] = if_r4.digest;  assign ov[2] = if_r4.out_valid;  assign ir[2] = if_r4.in_ready;  assign bz[2] = if_r4.busy;

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straightforward FIPS 180-4 compression over a fully expanded 64-word schedule.
  function automatic logic [255:0] ref_hash(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] W [64];
    logic [31:0] H [8];
    logic [31:0] s [8];
    logic [31:0] x1, x2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) W[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      W[i] = (rr(W[i-2], 17) ^ rr(W[i-2], 19) ^ (W[i-2] >> 10)) + W[i-7]
           + (rr(W[i-15], 7) ^ rr(W[i-15], 18) ^ (W[i-15] >> 3)) + W[i-16];
    for (int i = 0; i < 8; i++) begin H[i] = hin[255 - 32*i -: 32]; s[i] = H[i]; end
    for (int i = 0; i < 64; i++) begin
      x1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[i] + W[i];
      x2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      for (int k = 7; k > 0; k--) s[k] = s[k-1];
      s[4] = s[4] + x1;
      s[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = s[i] + H[i];
    return res;
  endfunction

  function automatic logic [511:0] present(input logic [511:0] blk);
    logic [511:0] o;
    o = blk;
`ifdef SHA256_BSWAP_EN
    for (int i = 0; i < 64; i++) o[8*i +: 8] = blk[8*(4*(i/4) + 3 - i%4) +: 8];
`endif
    return o;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic o, input logic i, input logic b);
    for (int r = 0; r < 3; r++) begin
      chk($sformatf("%s_out_valid_r%0d", name, r), 256'(ov[r]), 256'(o));
      chk($sformatf("%s_in_ready_r%0d", name, r), 256'(ir[r]), 256'(i));
      chk($sformatf("%s_busy_r%0d", name, r), 256'(bz[r]), 256'(b));
    end
  endtask

  task automatic start_block(input logic [511:0] blk, input logic ch, input logic [255:0] h);
    @(negedge clk);
    in_valid = 1'b1; in_block = present(blk); in_chain = ch; h_in = h;
    @(posedge clk); #1;
    in_valid = 1'b0; in_block = rand_block(); in_chain = ~ch; h_in = {8{$urandom()}};
  endtask

  task automatic wait_result(input string name, input logic [255:0] exp);
    int  lat  [3];
    bit  seen [3];
    bit  done;
    lat = '{0, 0, 0};
    seen = '{0, 0, 0};
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      done = 1'b1;
      for (int r = 0; r < 3; r++) begin
        if (!seen[r] && ov[r]) begin seen[r] = 1'b1; lat[r] = n; end
        if (!seen[r]) done = 1'b0;
      end
      if (done) break;
    end
    for (int r = 0; r < 3; r++) begin
      chk($sformatf("%s_latency_r%0d", name, r), 256'(lat[r]), 256'(LAT[r]));
      chk($sformatf("%s_digest_r%0d", name, r), dg[r], exp);
    end
  endtask

  task automatic release_out(input string name);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk_all({name, "_released"}, 1'b0, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic [511:0] blk;
    logic         ch;
    logic [255:0] h;
    bit           known;
    logic [255:0] exp;
  } vec_t;

  vec_t tv [4];
  logic [255:0] e, held;
  logic [511:0] rb;
  logic [255:0] rh;
  logic         rc;

  initial begin
    tv[0] = '{blk: ABC,    ch: 1'b0, h: IV,    known: 1'b1, exp: ABC_DIG};
    tv[1] = '{blk: TWO_B1, ch: 1'b0, h: IV,    known: 1'b0, exp: '0};
    tv[2] = '{blk: TWO_B2, ch: 1'b1, h: ~IV,   known: 1'b1, exp: TWO_DIG};
    tv[3] = '{blk: ABC,    ch: 1'b1, h: '0,    known: 1'b0, exp: '0};

    reset_n = 1'b0; in_valid = 1'b0; in_chain = 1'b0; out_ready = 1'b0;
    in_block = '0; h_in = '0; model_chain = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) chk($sformatf("reset_digest_r%0d", r), dg[r], '0);
    @(negedge clk); reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      e = tv[i].known ? tv[i].exp : ref_hash(tv[i].ch ? model_chain : tv[i].h, tv[i].blk);
      start_block(tv[i].blk, tv[i].ch, tv[i].h);
      wait_result($sformatf("tv%0d", i), e);
      model_chain = e;
      release_out($sformatf("tv%0d", i));
    end

    // Backpressure: a new block is offered while the previous digest waits.
    start_block(ABC, 1'b0, IV);
    wait_result("bp_first", ABC_DIG);
    held = ABC_DIG;
    model_chain = ABC_DIG;
    rb = rand_block(); rh = {8{$urandom()}};
    @(negedge clk); in_valid = 1'b1; in_block = present(rb); in_chain = 1'b0; h_in = rh;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk_all($sformatf("bp_hold%0d", k), 1'b1, 1'b0, 1'b1);
      for (int r = 0; r < 3; r++) chk($sformatf("bp_hold%0d_digest_r%0d", k, r), dg[r], held);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk_all("bp_idle", 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_block = rand_block(); h_in = ~rh;
    chk_all("bp_accept", 1'b0, 1'b0, 1'b1);
    e = ref_hash(rh, rb);
    wait_result("bp_second", e);
    model_chain = e;
    release_out("bp_second");

    // Reset in the middle of a block, then chain from the cleared register.
    start_block(ABC, 1'b0, IV);
    repeat (30) @(posedge clk);
    #2; reset_n = 1'b0; #1;
    chk_all("midreset", 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) chk($sformatf("midreset_digest_r%0d", r), dg[r], '0);
    model_chain = '0;
    @(negedge clk); reset_n = 1'b1;
    e = ref_hash('0, ABC);
    start_block(ABC, 1'b1, IV);
    wait_result("chain_from_zero", e);
    release_out("chain_from_zero");
    start_block(ABC, 1'b0, IV);
    wait_result("post_reset_abc", ABC_DIG);
    model_chain = ABC_DIG;
    release_out("post_reset_abc");

    for (int i = 0; i < 8; i++) begin
      rb = rand_block(); rh = {$urandom(), $urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom(), $urandom(), $urandom()};
      rc = 1'($urandom_range(0, 1));
      e = ref_hash(rc ? model_chain : rh, rb);
      start_block(rb, rc, rh);
      wait_result($sformatf("rand%0d", i), e);
      model_chain = e;
      release_out($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
